// File: rtl/dp_ram_pkg.sv
// -----------------------------------------------------------------------------
// dp_ram_pkg
// Shared definitions for the byte-enabled dual-port RAM:
//   - RW_READ_FIRST / RW_WRITE_FIRST : same-port read-during-write selectors
//   - be_width()                     : byte-enable width for a given word width
//   - byte_merge()                   : per-byte merge of a new word into an old one
// byte_merge() works on a fixed maximum width; callers size-cast their words
// in and the result back out, so one function serves every DATA_WIDTH.
// -----------------------------------------------------------------------------
package dp_ram_pkg;

    localparam int RW_READ_FIRST  = 0;
    localparam int RW_WRITE_FIRST = 1;

    localparam int MERGE_MAX_W  = 1024;
    localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_word,
        input logic [MERGE_MAX_W-1:0]  new_word,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_MAX_BE; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// -----------------------------------------------------------------------------
// dp_ram_rd_pipe
// Read-return pipeline for one RAM port: carries {valid, data, coll} through
// one or two reset-able register stages (READ_LATENCY = 1 or 2).
// Data registers only load on a valid beat, so rdata holds between accesses.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   vld_in       access accepted this edge
//   data_in      read word for this access
//   coll_in      collision detected for this access
//   rvalid       one-cycle strobe, READ_LATENCY edges after the access
//   rdata        read word, held while rvalid is low
//   coll         collision flag aligned with rvalid
// -----------------------------------------------------------------------------
module dp_ram_rd_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  coll_in,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  coll
);

    logic                  vld_p1;
    logic                  coll_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    // ---- stage p1: registered array read ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            coll_p1 <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= vld_in;
            coll_p1 <= vld_in & coll_in;
            if (vld_in) begin
                data_p1 <= data_in;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_p2
        logic                  vld_p2;
        logic                  coll_p2;
        logic [DATA_WIDTH-1:0] data_p2;

        // ---- stage p2: output register ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p2  <= 1'b0;
                coll_p2 <= 1'b0;
                data_p2 <= '0;
            end else begin
                vld_p2  <= vld_p1;
                coll_p2 <= coll_p1;
                if (vld_p1) begin
                    data_p2 <= data_p1;
                end
            end
        end

        assign rvalid = vld_p2;
        assign rdata  = data_p2;
        assign coll   = coll_p2;
    end else begin : g_p1
        assign rvalid = vld_p1;
        assign rdata  = data_p1;
        assign coll   = coll_p1;
    end

endmodule

// File: rtl/dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be
// True dual-port synchronous RAM with per-byte write enables, 1- or 2-cycle
// read latency, selectable same-port read-during-write, and deterministic
// cross-port collision handling with a collision flag.
// Ports (x = a, b):
//   clk, rst_n   clock, asynchronous active-low reset (array is not cleared)
//   cs_x         access request; one rvalid_x pulse per access
//   we_x, be_x   write and byte enables; we_x with be_x == 0 is a read
//   addr_x       word address; addresses >= DEPTH read 0 and ignore writes
//   wdata_x      write data
//   rdata_x      read data, held while rvalid_x is low
//   rvalid_x     read data strobe, READ_LATENCY edges after the access
//   coll         same-address access with at least one writer, aligned with rvalid
// Collision rules: A's enabled bytes win over B's; a reading port always sees
// the pre-write word; a writing port follows RW_MODE.
// -----------------------------------------------------------------------------
module dual_port_ram_be
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 6,
    parameter int DEPTH        = 2**ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int RW_MODE      = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cs_a,
    input  logic                            we_a,
    input  logic [be_width(DATA_WIDTH)-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]           addr_a,
    input  logic [DATA_WIDTH-1:0]           wdata_a,
    output logic [DATA_WIDTH-1:0]           rdata_a,
    output logic                            rvalid_a,
    input  logic                            cs_b,
    input  logic                            we_b,
    input  logic [be_width(DATA_WIDTH)-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]           addr_b,
    input  logic [DATA_WIDTH-1:0]           wdata_b,
    output logic [DATA_WIDTH-1:0]           rdata_b,
    output logic                            rvalid_b,
    output logic                            coll
);

    localparam int BE_W = be_width(DATA_WIDTH);

    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MERGE_MAX_W) begin : g_bad_data_width
        $error("dual_port_ram_be: DATA_WIDTH must be a multiple of 8 and <= %0d", MERGE_MAX_W);
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("dual_port_ram_be: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
        $error("dual_port_ram_be: DEPTH must be in 1..2**ADDR_WIDTH");
    end
    if (RW_MODE != RW_READ_FIRST && RW_MODE != RW_WRITE_FIRST) begin : g_bad_rw_mode
        $error("dual_port_ram_be: RW_MODE must be 0 or 1");
    end

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_W-1:0]       be
    );
        return DATA_WIDTH'(byte_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word),
                                      MERGE_MAX_BE'(be)));
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  in_a, in_b;
    logic                  wr_a, wr_b;
    logic                  same;
    logic                  coll_now;
    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] fin_a, fin_b;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    logic                  coll_pa, coll_pb;

    always_comb begin
        in_a  = int'(addr_a) < DEPTH;
        in_b  = int'(addr_b) < DEPTH;
        old_a = in_a ? mem[addr_a] : '0;
        old_b = in_b ? mem[addr_b] : '0;
        same  = cs_a & cs_b & (addr_a == addr_b);
        wr_a  = cs_a & we_a & (|be_a) & in_a;
        wr_b  = cs_b & we_b & (|be_b) & in_b;

        // B's bytes go in first so A's enabled bytes overwrite them on a
        // write/write collision; both ports then agree on the final word.
        fin_a = merge((same && wr_b) ? merge(old_a, wdata_b, be_b) : old_a, wdata_a, be_a);
        fin_b = (same && wr_a) ? fin_a : merge(old_b, wdata_b, be_b);

        coll_now = same & ((we_a & (|be_a)) | (we_b & (|be_b)));

        // Only the writing port may see the merged word; a port that is
        // merely reading always returns the pre-write contents.
        rd_a = (RW_MODE == RW_WRITE_FIRST && wr_a) ? fin_a : old_a;
        rd_b = (RW_MODE == RW_WRITE_FIRST && wr_b) ? fin_b : old_b;
    end

    // Array has no reset; writes are blocked while rst_n is low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_a) begin
                mem[addr_a] <= fin_a;
            end
            if (wr_b && !(same && wr_a)) begin
                mem[addr_b] <= fin_b;
            end
        end
    end

    dp_ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (cs_a),
        .data_in (rd_a),
        .coll_in (coll_now),
        .rvalid  (rvalid_a),
        .rdata   (rdata_a),
        .coll    (coll_pa)
    );

    dp_ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (cs_b),
        .data_in (rd_b),
        .coll_in (1'b0),
        .rvalid  (rvalid_b),
        .rdata   (rdata_b),
        .coll    (coll_pb)
    );

    // Collision is carried by port A's pipe; B's pipe is fed 0 and folds away.
    assign coll = coll_pa | coll_pb;

endmodule
